alu_serial: RTL and testbench



---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_slice.sv | 52 +++++
 rtl/alu_serial.sv | 155 +++++++++++++++
 tb/tb_alu_serial.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, FSM states and carry-seed helper for the serial ALU
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_ADC  = 3'd2,
        OP_SBC  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_XOR  = 3'd6,
        OP_SETA = 3'd7
    } alu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } alu_state_e;

    // Carry injected into slice 0; logic ops keep the chain at zero.
    function automatic logic carry_seed(input alu_op_e op, input logic cin);
        logic seed;
        seed = 1'b0;
        case (op)
            OP_SUB:         seed = 1'b1;
            OP_ADC, OP_SBC: seed = cin;
            default:        seed = 1'b0;
        endcase
        return seed;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_slice.sv
// ============================================================================
// alu_slice : combinational SLICE-bit ALU cell with ripple carry chain
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_slice
    import alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  alu_op_e          op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             c_in,
    output logic [SLICE-1:0] f_s,
    output logic             c_out,
    output logic             c_msb
);

    always_comb begin
        logic c;
        logic bb;
        logic inv;
        f_s   = '0;
        c_out = 1'b0;
        c_msb = 1'b0;
        c     = c_in;
        bb    = 1'b0;
        inv   = (op == OP_SUB) || (op == OP_SBC);
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                for (int i = 0; i < SLICE; i++) begin
                    bb = b_s[i] ^ inv;
                    if (i == SLICE - 1) begin
                        c_msb = c;
                    end
                    f_s[i] = a_s[i] ^ bb ^ c;
                    c      = (a_s[i] & bb) | (a_s[i] & c) | (bb & c);
                end
                c_out = c;
            end
            OP_AND:  f_s = a_s & b_s;
            OP_OR:   f_s = a_s | b_s;
            OP_XOR:  f_s = a_s ^ b_s;
            default: f_s = a_s;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ============================================================================
// alu_serial : WIDTH-bit ALU processed SLICE bits per clock, LSB slice first.
// Optional signed-overflow flag built when ALU_SERIAL_OVF_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int SLICE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    output logic [WIDTH-1:0]    f,
    output logic                cout,
    output logic                zero,
    output logic                ovf,
    output logic                busy,
    output logic                done
);

    localparam int NS = WIDTH / SLICE;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;

    if ((SLICE < 1) || (SLICE > WIDTH) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
        $error("alu_serial: WIDTH must be a positive multiple of SLICE");
    end

    alu_state_e       state_q;
    alu_op_e          op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] f_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             zacc_q;
    logic             cout_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;

    logic [SLICE-1:0] a_s_w;
    logic [SLICE-1:0] b_s_w;
    logic [SLICE-1:0] f_s_w;
    logic             c_out_w;
    logic             c_msb_w;
    logic             accept_w;
    logic             last_w;
    logic             slice_zero_w;

    assign a_s_w        = a_q[int'(cnt_q)*SLICE +: SLICE];
    assign b_s_w        = b_q[int'(cnt_q)*SLICE +: SLICE];
    assign accept_w     = (state_q == ST_IDLE) && start;
    assign last_w       = (state_q == ST_RUN) && (cnt_q == CW'(NS - 1));
    assign slice_zero_w = (f_s_w == '0);

    alu_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op    (op_q),
        .a_s   (a_s_w),
        .b_s   (b_s_w),
        .c_in  (carry_q),
        .f_s   (f_s_w),
        .c_out (c_out_w),
        .c_msb (c_msb_w)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= alu_op_e'(op);
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= carry_seed(alu_op_e'(op), cin);
                        f_q     <= '0;
                        cout_q  <= 1'b0;
                        zero_q  <= 1'b0;
                        zacc_q  <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    f_q[int'(cnt_q)*SLICE +: SLICE] <= f_s_w;
                    carry_q <= c_out_w;
                    zacc_q  <= zacc_q & slice_zero_w;
                    if (last_w) begin
                        // Logic ops leave c_out at 0, so cout needs no op check.
                        cout_q  <= c_out_w;
                        zero_q  <= zacc_q & slice_zero_w;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (reset || accept_w) begin
            ovf_q <= 1'b0;
        end else if (last_w) begin
            ovf_q <= c_msb_w ^ c_out_w;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_sig;
    assign unused_ovf_sig = c_msb_w ^ accept_w;
    assign ovf            = 1'b0;
`endif

    assign f    = f_q;
    assign cout = cout_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// ============================================================================
// tb_alu_serial : directed self-checking bench for 36/4 and 8/1 builds
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_serial;

    localparam logic [2:0] T_ADD = 3'd0;
    localparam logic [2:0] T_SUB = 3'd1;
    localparam logic [2:0] T_ADC = 3'd2;
    localparam logic [2:0] T_SBC = 3'd3;
    localparam logic [2:0] T_XOR = 3'd6;

`ifdef ALU_SERIAL_OVF_EN
    localparam logic EXP_OVF1 = 1'b1;
`else
    localparam logic EXP_OVF1 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [35:0] a = '0;
    logic [35:0] b = '0;
    logic        cin = 1'b0;
    logic [35:0] f;
    logic        cout, zero, ovf, busy, done;

    logic        s8_start = 1'b0;
    logic [2:0]  s8_op = 3'd0;
    logic [7:0]  s8_a = '0;
    logic [7:0]  s8_b = '0;
    logic        s8_cin = 1'b0;
    logic [7:0]  s8_f;
    logic        s8_cout, s8_zero, s8_ovf, s8_busy, s8_done;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_serial #(.WIDTH(36), .SLICE(4)) u_dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .f(f), .cout(cout), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
    );

    alu_serial #(.WIDTH(8), .SLICE(1)) u_dut8 (
        .clk(clk), .reset(reset), .start(s8_start), .op(s8_op), .a(s8_a), .b(s8_b), .cin(s8_cin),
        .f(s8_f), .cout(s8_cout), .zero(s8_zero), .ovf(s8_ovf), .busy(s8_busy), .done(s8_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a request; returns #1 after the accepting edge.
    task automatic go36(input logic [2:0] o, input logic [35:0] x, input logic [35:0] y, input logic c);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait36(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic wait8(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!s8_done && n < 40);
    endtask

    initial begin
        int n;
        int dones;
        int first;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_f", 64'(f), 64'h0);
        chk("rst_flags", {60'h0, cout, zero, ovf, done}, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: signed overflow boundary
        go36(T_ADD, 36'h7_FFFF_FFFF, 36'h1, 1'b0);
        chk("t1_busy", 64'(busy), 64'h1);
        chk("t1_f_clr", 64'(f), 64'h0);
        wait36(n);
        chk("t1_lat", 64'(n), 64'd9);
        chk("t1_f", 64'(f), 64'h8_0000_0000);
        chk("t1_cout_zero", {62'h0, cout, zero}, 64'h0);
        chk("t1_ovf", 64'(ovf), 64'(EXP_OVF1));
        chk("t1_busy_end", 64'(busy), 64'h0);

        // 2: subtraction
        go36(T_SUB, 36'd5, 36'd5, 1'b0);
        wait36(n);
        chk("t2a_f", 64'(f), 64'h0);
        chk("t2a_flags", {61'h0, cout, zero, ovf}, 64'b110);
        go36(T_SUB, 36'd3, 36'd5, 1'b0);
        wait36(n);
        chk("t2b_f", 64'(f), 64'hF_FFFF_FFFE);
        chk("t2b_flags", {61'h0, cout, zero, ovf}, 64'b000);

        // 3: carry-in variants
        go36(T_SBC, 36'h0, 36'h0, 1'b0);
        wait36(n);
        chk("t3a_f", 64'(f), 64'hF_FFFF_FFFF);
        chk("t3a_flags", {61'h0, cout, zero, ovf}, 64'b000);
        go36(T_ADC, 36'hF_FFFF_FFFF, 36'h0, 1'b1);
        wait36(n);
        chk("t3b_f", 64'(f), 64'h0);
        chk("t3b_flags", {61'h0, cout, zero, ovf}, 64'b110);

        // 4: XOR with start pulses while busy
        go36(T_XOR, 36'hA_AAAA_AAAA, 36'h5_5555_5555, 1'b0);
        dones = 0;
        first = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3 || i == 5) begin
                op = T_ADD; a = 36'h1; b = 36'h1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        start = 1'b0;
        chk("t4_dones", 64'(dones), 64'd1);
        chk("t4_lat", 64'(first), 64'd9);
        chk("t4_f", 64'(f), 64'hF_FFFF_FFFF);
        chk("t4_flags", {61'h0, cout, zero, ovf}, 64'b000);

        // 5: reset mid-operation
        go36(T_ADD, 36'h1_2345_6789, 36'h0_1111_1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_f", 64'(f), 64'h0);
        chk("t5_done", 64'(done), 64'h0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("t5_nodone", 64'(dones), 64'd0);
        go36(T_ADD, 36'd1, 36'd2, 1'b0);
        wait36(n);
        chk("t5_lat", 64'(n), 64'd9);
        chk("t5_f2", 64'(f), 64'd3);

        // 6: bit-serial build, back-to-back
        s8_op = T_ADD; s8_a = 8'hFF; s8_b = 8'h01; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        wait8(n);
        chk("t6_lat", 64'(n), 64'd8);
        chk("t6_f", 64'(s8_f), 64'h0);
        chk("t6_flags", {62'h0, s8_cout, s8_zero}, 64'b11);
        s8_op = T_ADD; s8_a = 8'h03; s8_b = 8'h04; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        chk("t6_b2b_busy", 64'(s8_busy), 64'h1);
        chk("t6_b2b_done", 64'(s8_done), 64'h0);
        wait8(n);
        chk("t6_lat2", 64'(n), 64'd8);
        chk("t6_f2", 64'(s8_f), 64'h07);
        chk("t6_flags2", {62'h0, s8_cout, s8_zero}, 64'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
